// File: rtl/input_debounce_sync.sv
// Per-channel 2-FF synchroniser, counter debounce and registered rise/fall pulses for board pins.
// Optional sticky press-event flags are built only when DEBOUNCE_EVENT_LATCH_EN is defined.
module input_debounce_sync #(
  parameter int unsigned      N_CH            = 12,
  parameter int unsigned      DEBOUNCE_CYCLES = 500000,
  parameter int unsigned      CNT_W           = $clog2(DEBOUNCE_CYCLES + 1),
  parameter logic [N_CH-1:0]  RESET_VAL       = 12'h00F
) (
  input  logic            clk_clk,
  input  logic            reset_reset_n,
  input  logic [N_CH-1:0] raw_i,
  output logic [N_CH-1:0] db_o,
  output logic [N_CH-1:0] rise_o,
  output logic [N_CH-1:0] fall_o,
  input  logic [N_CH-1:0] event_clr_i,
  output logic [N_CH-1:0] event_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_CH-1:0]            r_s1;
  logic [N_CH-1:0]            r_s2;
  logic [N_CH-1:0]            r_db;
  logic [N_CH-1:0]            r_rise;
  logic [N_CH-1:0]            r_fall;
  logic [N_CH-1:0][CNT_W-1:0] r_cnt;

  logic [N_CH-1:0]            w_db_d;
  logic [N_CH-1:0]            w_rise_d;
  logic [N_CH-1:0]            w_fall_d;
  logic [N_CH-1:0][CNT_W-1:0] w_cnt_d;

  // cnt==0 is the idle state; any return of s2 to db_o restarts the count.
  always_comb begin
    w_db_d   = r_db;
    w_rise_d = '0;
    w_fall_d = '0;
    w_cnt_d  = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (r_s2[i] != r_db[i]) begin
        if (r_cnt[i] == CNT_MAX) begin
          w_db_d[i]   = r_s2[i];
          w_rise_d[i] = r_s2[i];
          w_fall_d[i] = ~r_s2[i];
        end else begin
          w_cnt_d[i] = r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_s1   <= RESET_VAL;
      r_s2   <= RESET_VAL;
      r_db   <= RESET_VAL;
      r_rise <= '0;
      r_fall <= '0;
      r_cnt  <= '0;
    end else begin
      r_s1   <= raw_i;
      r_s2   <= r_s1;
      r_db   <= w_db_d;
      r_rise <= w_rise_d;
      r_fall <= w_fall_d;
      r_cnt  <= w_cnt_d;
    end
  end

  assign db_o   = r_db;
  assign rise_o = r_rise;
  assign fall_o = r_fall;

`ifdef DEBOUNCE_EVENT_LATCH_EN
  logic [N_CH-1:0] r_event;

  // A new press in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_event <= '0;
    end else begin
      r_event <= (r_event & ~event_clr_i) | r_fall;
    end
  end

  assign event_o = r_event;
`else
  logic w_unused_clr;
  assign w_unused_clr = ^event_clr_i;
  assign event_o      = '0;
`endif

endmodule

// File: tb/tb_input_debounce_sync.sv
// Scoreboard bench for input_debounce_sync with DEBOUNCE_CYCLES=4; pulses are checked by a monitor.
module tb_input_debounce_sync;

  localparam int DC  = 4;
  localparam int LAT = 2 + DC;

  logic        clk;
  logic        rst_n;
  logic [11:0] raw;
  logic [11:0] clr;
  logic [11:0] db;
  logic [11:0] rise;
  logic [11:0] fall;
  logic [11:0] ev;

  int cyc      = 0;
  int checks   = 0;
  int failures = 0;

  typedef struct {
    int          cyc;
    logic [11:0] rise;
    logic [11:0] fall;
    logic [11:0] db;
  } exp_t;

  exp_t sb_q[$];

  input_debounce_sync #(
    .N_CH           (12),
    .DEBOUNCE_CYCLES(DC),
    .RESET_VAL      (12'h00F)
  ) dut (
    .clk_clk      (clk),
    .reset_reset_n(rst_n),
    .raw_i        (raw),
    .db_o         (db),
    .rise_o       (rise),
    .fall_o       (fall),
    .event_clr_i  (clr),
    .event_o      (ev)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [11:0] r, input logic [11:0] f, input logic [11:0] d);
    exp_t e;
    e.cyc  = cyc + LAT;
    e.rise = r;
    e.fall = f;
    e.db   = d;
    sb_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: every nonzero pulse must match the next expected transition.
  always @(negedge clk) begin
    exp_t e;
    if (rise != 12'h000 || fall != 12'h000) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse rise=%h fall=%h db=%h (cycle %0d)", rise, fall, db, cyc);
      end else begin
        e = sb_q.pop_front();
        chk("pulse_cycle", cyc, e.cyc);
        chk("pulse_rise", rise, e.rise);
        chk("pulse_fall", fall, e.fall);
        chk("pulse_db", db, e.db);
      end
    end
`ifndef DEBOUNCE_EVENT_LATCH_EN
    chk("event_off", ev, 12'h000);
`endif
  end

  logic [11:0] ev_exp;

  initial begin
    rst_n = 1'b0;
    raw   = 12'hAAA;
    clr   = 12'h000;

    // Reset state while raw differs from the reset value.
    step(3);
    @(negedge clk);
    chk("reset_db", db, 12'h00F);
    chk("reset_rise", rise, 12'h000);
    chk("reset_fall", fall, 12'h000);
    chk("reset_event", ev, 12'h000);
    step(1);
    rst_n = 1'b1;
    push(12'hAA0, 12'h005, 12'hAAA);
    step(10);

    // Three-cycle glitch on KEY[1] is discarded.
    raw[1] = 1'b0;
    step(3);
    raw[1] = 1'b1;
    step(10);
    chk("glitch_db", db, 12'hAAA);

    // Held press on KEY[1], then release.
    raw[1] = 1'b0;
    push(12'h000, 12'h002, 12'hAA8);
    step(10);
    raw[1] = 1'b1;
    push(12'h002, 12'h000, 12'hAAA);
    step(10);

    // SW[1] (bit 5): settle low, chatter every 2 cycles, then settle high.
    raw[5] = 1'b0;
    push(12'h000, 12'h020, 12'hA8A);
    step(10);
    for (int i = 0; i < 10; i++) begin
      raw[5] = ~raw[5];
      step(2);
    end
    raw[5] = 1'b1;
    push(12'h020, 12'h000, 12'hAAA);
    step(10);

    // Return to the reset pattern, then reset during a count on KEY[2].
    raw = 12'h00F;
    push(12'h005, 12'hAA0, 12'h00F);
    step(10);
    raw[2] = 1'b0;
    step(5);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midreset_db", db, 12'h00F);
    chk("midreset_fall", fall, 12'h000);
    step(2);
    rst_n = 1'b1;
    push(12'h000, 12'h004, 12'h00B);
    step(10);

    // Event flags: set by press, lone clear, clear racing a new press, lone clear.
    raw[3] = 1'b0;
    push(12'h000, 12'h008, 12'h003);
    step(8);
`ifdef DEBOUNCE_EVENT_LATCH_EN
    ev_exp = 12'h00C;
`else
    ev_exp = 12'h000;
`endif
    chk("event_set", ev, ev_exp);
    clr = 12'h00C;
    step(1);
    clr = 12'h000;
    chk("event_clear", ev, 12'h000);
    raw[3] = 1'b1;
    push(12'h008, 12'h000, 12'h00B);
    step(10);
    raw[3] = 1'b0;
    push(12'h000, 12'h008, 12'h003);
    step(LAT);
    clr = 12'h008;
    step(1);
    clr = 12'h000;
`ifdef DEBOUNCE_EVENT_LATCH_EN
    ev_exp = 12'h008;
`else
    ev_exp = 12'h000;
`endif
    chk("event_set_wins", ev, ev_exp);
    step(2);
    clr = 12'h008;
    step(1);
    clr = 12'h000;
    chk("event_clear2", ev, 12'h000);

    step(3);
    chk("sb_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
